// File: rtl/bcd_modcnt_if.sv
// Handshake-free control/status bundle for bcd_modcnt.
// master drives clr/load/load_val/dir/enin/inc; slave returns digits, enout, load_err.
interface bcd_modcnt_if;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic       enin;
  logic       inc;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       enout;
  logic       load_err;

  modport master (
    output clr, load, load_val, dir, enin, inc,
    input  ones, tens, enout, load_err
  );

  modport slave (
    input  clr, load, load_val, dir, enin, inc,
    output ones, tens, enout, load_err
  );
endinterface

// File: rtl/bcd_modcnt.sv
// Two-digit BCD modulo counter: up/down, BCD load, cascade enin->enout, manual inc.
// Ports: clk, rst_n (sync, active-low), bus (bcd_modcnt_if.slave).
// Macro BCD_MODCNT_AUTOREPEAT_EN adds hold-to-repeat on inc (REPEAT_DELAY/PERIOD).
module bcd_modcnt #(
  parameter int MODULO        = 60,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_modcnt_if.slave  bus
);

  localparam logic [3:0] MAX_T = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MODULO - 1) % 10);

  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       err_q;
  logic       inc_q;
  logic       inc_step;
  logic       step;
  logic       at_max;
  logic       at_zero;
  logic [7:0] lv;
  logic       ld_bad;

  assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  assign lv = 8'(bus.load_val[7:4]) * 8'd10
            + 8'(bus.load_val[3:0]);
  assign ld_bad = (bus.load_val[7:4] > 4'd9)
               || (bus.load_val[3:0] > 4'd9)
               || (lv >= 8'(MODULO));

`ifdef BCD_MODCNT_AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } st_t;

  st_t           st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
    end else if (bus.clr || bus.load) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.inc && !inc_q) begin
            st  <= HOLD;
            cnt <= CW'(1);
          end
        end
        HOLD: begin
          if (!bus.inc) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == CW'(REPEAT_DELAY)) begin
            st  <= RPT;
            cnt <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RPT: begin
          if (!bus.inc) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == CW'(REPEAT_PERIOD)) begin
            cnt <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    inc_step = 1'b0;
    unique case (st)
      IDLE: inc_step = bus.inc && !inc_q;
      HOLD: inc_step = bus.inc
                    && (cnt == CW'(REPEAT_DELAY));
      RPT:  inc_step = bus.inc
                    && (cnt == CW'(REPEAT_PERIOD));
      default: inc_step = 1'b0;
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign inc_step   = bus.inc && !inc_q;
`endif

  assign step = bus.enin || inc_step;

  // Cascade only on enin; manual stepping never propagates.
  assign bus.enout = bus.enin && !bus.clr && !bus.load
                  && rst_n
                  && (bus.dir ? at_max : at_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      err_q  <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      inc_q <= bus.inc;
      err_q <= 1'b0;
      if (bus.clr) begin
        ones_q <= 4'd0;
        tens_q <= 4'd0;
      end else if (bus.load) begin
        if (ld_bad) begin
          ones_q <= 4'd0;
          tens_q <= 4'd0;
          err_q  <= 1'b1;
        end else begin
          ones_q <= bus.load_val[3:0];
          tens_q <= bus.load_val[7:4];
        end
      end else if (step) begin
        if (bus.dir) begin
          if (at_max) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
          end else if (ones_q == 4'd9) begin
            ones_q <= 4'd0;
            tens_q <= tens_q + 4'd1;
          end else begin
            ones_q <= ones_q + 4'd1;
          end
        end else begin
          if (at_zero) begin
            ones_q <= MAX_O;
            tens_q <= MAX_T;
          end else if (ones_q == 4'd0) begin
            ones_q <= 4'd9;
            tens_q <= tens_q - 4'd1;
          end else begin
            ones_q <= ones_q - 4'd1;
          end
        end
      end
    end
  end

  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_modcnt.sv
// Directed bench for bcd_modcnt: mod-60 and mod-24 instances side by side.
// Covers reset, wrap/borrow, cascade, load legality, priority, manual stepping.
module tb_bcd_modcnt;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;

  bcd_modcnt_if b60 ();
  bcd_modcnt_if b24 ();

  bcd_modcnt #(.MODULO(60)) u60 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b60)
  );

  bcd_modcnt #(.MODULO(24)) u24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int v60();
    return int'({b60.tens, b60.ones});
  endfunction

  function automatic int v24();
    return int'({b24.tens, b24.ones});
  endfunction

  task automatic load60(input logic [7:0] v);
    b60.load     = 1'b1;
    b60.load_val = v;
    tick();
    b60.load     = 1'b0;
  endtask

  task automatic load24(input logic [7:0] v);
    b24.load     = 1'b1;
    b24.load_val = v;
    tick();
    b24.load     = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    {b60.clr, b60.load, b60.dir, b60.enin, b60.inc} = '0;
    {b24.clr, b24.load, b24.dir, b24.enin, b24.inc} = '0;
    b60.load_val = 8'h00;
    b24.load_val = 8'h00;

    // reset, with enin high: enout must stay low
    b60.enin = 1'b1;
    b60.dir  = 1'b0;
    tick();
    #1;
    chk("rst_enout", int'(b60.enout), 0);
    tick();
    chk("rst_val", v60(), 'h00);
    chk("rst_err", int'(b60.load_err), 0);
    b60.enin = 1'b0;
    rst_n = 1'b1;

    // test 1: count up 59 cycles
    b60.dir  = 1'b1;
    b60.enin = 1'b1;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (i == 9) chk("up_10", v60(), 'h10);
    end
    #1;
    chk("up_59", v60(), 'h59);
    chk("up_59_enout", int'(b60.enout), 1);
    tick();
    #1;
    chk("up_wrap", v60(), 'h00);
    chk("up_wrap_enout", int'(b60.enout), 0);

    // test 2: count down from 00
    b60.dir = 1'b0;
    #1;
    chk("dn_00_enout", int'(b60.enout), 1);
    tick();
    chk("dn_59", v60(), 'h59);
    tick();
    chk("dn_58", v60(), 'h58);
    b60.enin = 1'b0;

    // borrow across tens
    load60(8'h10);
    b60.enin = 1'b1;
    tick();
    chk("dn_09", v60(), 'h09);
    b60.enin = 1'b0;

    // test 6b: clr beats enin at 59
    load60(8'h59);
    chk("ld_59", v60(), 'h59);
    b60.enin = 1'b1;
    b60.dir  = 1'b1;
    b60.clr  = 1'b1;
    #1;
    chk("clr_enout", int'(b60.enout), 0);
    tick();
    chk("clr_val", v60(), 'h00);
    b60.clr  = 1'b0;
    b60.enin = 1'b0;

    // test 6a: reset beats enin at 37
    load60(8'h37);
    chk("ld_37", v60(), 'h37);
    b60.enin = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst37_enout", int'(b60.enout), 0);
    tick();
    chk("rst37_val", v60(), 'h00);
    rst_n = 1'b1;
    b60.enin = 1'b0;

    // clr beats load
    b60.clr      = 1'b1;
    b60.load     = 1'b1;
    b60.load_val = 8'h30;
    tick();
    chk("clr_ld", v60(), 'h00);
    b60.clr  = 1'b0;
    b60.load = 1'b0;

    // illegal load on mod-60
    load60(8'h42);
    load60(8'h60);
    chk("ld60_val", v60(), 'h00);
    chk("ld60_err", int'(b60.load_err), 1);
    tick();
    chk("ld60_err_off", int'(b60.load_err), 0);

    // test 3: mod-24
    load24(8'h23);
    chk("m24_23", v24(), 'h23);
    b24.dir  = 1'b1;
    b24.enin = 1'b1;
    #1;
    chk("m24_enout", int'(b24.enout), 1);
    tick();
    chk("m24_wrap", v24(), 'h00);
    b24.enin = 1'b0;
    load24(8'h15);
    load24(8'h24);
    chk("m24_24_val", v24(), 'h00);
    chk("m24_24_err", int'(b24.load_err), 1);
    tick();
    chk("m24_24_off", int'(b24.load_err), 0);
    load24(8'h12);
    load24(8'h1A);
    chk("m24_1a_val", v24(), 'h00);
    chk("m24_1a_err", int'(b24.load_err), 1);
    tick();
    chk("m24_1a_off", int'(b24.load_err), 0);

`ifdef BCD_MODCNT_AUTOREPEAT_EN
    // test 5: held 20 cycles -> steps at 0, 8, 12, 16
    b60.clr = 1'b1;
    tick();
    b60.clr = 1'b0;
    b60.dir = 1'b1;
    b60.inc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0)  chk("rpt_c0", v60(), 'h01);
      if (i == 8)  chk("rpt_c8", v60(), 'h02);
      if (i == 11) chk("rpt_c11", v60(), 'h02);
    end
    chk("rpt_end", v60(), 'h04);
    b60.inc = 1'b0;
    tick();
    chk("rpt_rel", v60(), 'h04);
`else
    // test 4: held inc steps once, never cascades
    load60(8'h05);
    b60.dir = 1'b1;
    b60.inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0)
        chk("inc_enout", int'(b60.enout), 0);
      tick();
    end
    chk("inc_hold", v60(), 'h06);
    b60.inc = 1'b0;
    tick();
    chk("inc_rel", v60(), 'h06);
`endif

    // enin and inc together -> single step
    load60(8'h06);
    b60.dir  = 1'b1;
    b60.enin = 1'b1;
    b60.inc  = 1'b1;
    tick();
    chk("enin_inc", v60(), 'h07);
    b60.enin = 1'b0;
    b60.inc  = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
